// File: rtl/memory_pkg.sv
// Shared widths and types for the single-port scratch RAM.
// Defaults give a 32-word by 3-bit store.
package memory_pkg;

    localparam int MEM_DATA_W = 3;
    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

    typedef logic [MEM_DATA_W-1:0] data_t;
    typedef logic [MEM_ADDR_W-1:0] addr_t;

endpackage : memory_pkg

// File: rtl/memory.sv
// Single-port synchronous RAM with a shared read/write address and a registered,
// write-first output. A synchronous reset clears both the array and the output.
module memory
    import memory_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] data_out_r;

    // Storage and output register: reset beats write, write beats read.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r      <= '{default: {DATA_W{1'b0}}};
            data_out_r <= {DATA_W{1'b0}};
        end else if (write) begin
            mem_r[addr] <= data_in;
            data_out_r  <= data_in;
        end else begin
            data_out_r <= mem_r[addr];
        end
    end

    assign data_out = data_out_r;

endmodule : memory

// File: tb/tb_memory.sv
// Directed self-checking bench for the scratch RAM: reset clearing, write-through,
// word isolation, address boundaries, overwrite and reset during a write.
module tb_memory;
    import memory_pkg::*;

    logic  clk;
    logic  reset;
    logic  write;
    data_t data_in;
    addr_t addr;
    data_t data_out;

    int check_cnt;
    int error_cnt;

    memory dut (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .data_in  (data_in),
        .addr     (addr),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input data_t obs, input data_t exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs for one rising edge, then compare just after it.
    task automatic step(input string tag, input logic rst, input logic wr,
                        input addr_t a, input data_t d, input data_t exp);
        reset   = rst;
        write   = wr;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        check_val(tag, data_out, exp);
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        reset   = 1'b1;
        write   = 1'bx;
        addr    = 5'd0;
        data_in = 3'bxxx;
        @(negedge clk);

        // Reset with write undriven, held for two edges.
        step("reset_1", 1'b1, 1'bx, 5'd0, 3'bxxx, 3'b000);
        step("reset_2", 1'b1, 1'bx, 5'd9, 3'bxxx, 3'b000);

        // Cleared array reads as zero.
        step("rd_clr_0",  1'b0, 1'b0, 5'd0,  3'b000, 3'b000);
        step("rd_clr_11", 1'b0, 1'b0, 5'd11, 3'b000, 3'b000);
        step("rd_clr_31", 1'b0, 1'b0, 5'd31, 3'b000, 3'b000);

        // Write-through, then read back.
        step("wr_11",     1'b0, 1'b1, 5'd11, 3'b110, 3'b110);
        step("rd_11",     1'b0, 1'b0, 5'd11, 3'b000, 3'b110);

        // Output holds between edges.
        #3;
        check_val("hold_11", data_out, 3'b110);

        // Second word leaves the first untouched.
        step("wr_4",      1'b0, 1'b1, 5'd4,  3'b101, 3'b101);
        step("rd_4",      1'b0, 1'b0, 5'd4,  3'b000, 3'b101);
        step("rd_11_b",   1'b0, 1'b0, 5'd11, 3'b000, 3'b110);
        step("rd_5",      1'b0, 1'b0, 5'd5,  3'b000, 3'b000);

        // Address boundaries.
        step("wr_0",      1'b0, 1'b1, 5'd0,  3'b111, 3'b111);
        step("wr_31",     1'b0, 1'b1, 5'd31, 3'b010, 3'b010);
        step("rd_0",      1'b0, 1'b0, 5'd0,  3'b000, 3'b111);
        step("rd_31",     1'b0, 1'b0, 5'd31, 3'b000, 3'b010);
        step("rd_1",      1'b0, 1'b0, 5'd1,  3'b000, 3'b000);
        step("rd_30",     1'b0, 1'b0, 5'd30, 3'b000, 3'b000);

        // Overwrite the same word on consecutive edges.
        step("wr_7_a",    1'b0, 1'b1, 5'd7,  3'b011, 3'b011);
        step("wr_7_b",    1'b0, 1'b1, 5'd7,  3'b100, 3'b100);
        step("rd_7",      1'b0, 1'b0, 5'd7,  3'b000, 3'b100);

        // Reset coincident with a write discards the write and clears everything.
        step("rst_wr",    1'b1, 1'b1, 5'd11, 3'b001, 3'b000);
        step("rd_4_rst",  1'b0, 1'b0, 5'd4,  3'b000, 3'b000);
        step("rd_7_rst",  1'b0, 1'b0, 5'd7,  3'b000, 3'b000);
        step("rd_11_rst", 1'b0, 1'b0, 5'd11, 3'b000, 3'b000);
        step("rd_31_rst", 1'b0, 1'b0, 5'd31, 3'b000, 3'b000);
        step("rd_0_rst",  1'b0, 1'b0, 5'd0,  3'b000, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule : tb_memory
